uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rx_sync.sv | 26 ++
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling default
// and parity mode, used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEF = 16;

    // 1 = even parity, 0 = odd parity
    localparam logic PARITY_EVEN = 1'b1;

    // Parity error from the XOR of the data bits and the received parity bit
    function automatic logic par_err(input logic data_xor, input logic par_bit);
        return data_xor ^ par_bit ^ ~PARITY_EVEN;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so a reset never looks like a start bit.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start/data/parity/stop framing,
// registered result with a one-clock data_valid pulse.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    logic w_rx;

    uart_state_t      r_state, w_state_nxt;
    logic [TW-1:0]    r_tick, w_tick_nxt;
    logic [BW-1:0]    r_bit, w_bit_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             r_par, w_par_nxt;
    logic             r_stop, w_stop_nxt;
    logic             r_done, w_done_nxt;
    logic             r_armed, w_armed_nxt;
    logic             w_load;

    rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_stop  <= 1'b1;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_stop  <= w_stop_nxt;
            r_done  <= w_done_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // Next-state logic; everything but the post-stop commit waits for a tick
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_stop_nxt  = r_stop;
        w_done_nxt  = r_done;
        w_armed_nxt = r_armed;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rx) w_armed_nxt = 1'b1;
                if (baud_tick && r_armed && !w_rx) begin
                    w_state_nxt = ST_START;
                    w_tick_nxt  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (r_tick == TICK_HALF) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_rx, r_shift[WIDTH-1:1]};
                        if (r_bit == BIT_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_bit_nxt = r_bit + BW'(1);
                        end
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_par_nxt   = w_rx;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (r_done) begin
                    w_load      = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (!r_stop) w_armed_nxt = 1'b0;
                end else if (baud_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt = '0;
                        w_stop_nxt = w_rx;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers, updated together when a frame commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= w_load;
            if (w_load) begin
                data_out   <= r_shift;
                parity_err <= par_err(^r_shift, r_par);
                frame_err  <= ~r_stop;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
